// File: rtl/screen_scanner.sv
// screen_scanner: transposes the 64x32 frame buffer into SSD1306 page bytes.
// Ports: clk/rst_n, start/busy/frame_done, mem_read* client, out_* byte stream.
// Optional SCANNER_HDOUBLE_EN emits every column byte twice (128-wide panel).
module screen_scanner #(
  parameter logic [11:0] FB_BASE = 12'h100,
  parameter int          PAGES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        mem_read,
  output logic [11:0] mem_read_idx,
  input  logic [7:0]  mem_read_byte,
  input  logic        mem_read_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_first
);

  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
`ifdef SCANNER_HDOUBLE_EN
  localparam int JW = 4;
`else
  localparam int JW = 3;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [PW-1:0]   p;
  logic [2:0]      c;
  logic [2:0]      r;
  logic [JW-1:0]   j;
  logic [2:0]      col;
  logic [7:0]      rows [8];
  logic            done_q;
  logic            hs;
  logic            j_last;
  logic            last_blk;
  logic [11:0]     rd_off;

`ifdef SCANNER_HDOUBLE_EN
  // two consecutive handshakes share one pixel column
  assign col = j[3:1];
`else
  assign col = j;
`endif

  assign j_last   = &j;
  assign last_blk = (c == 3'd7) && (p == PW'(PAGES - 1));
  assign hs       = (state == EMIT) && out_ready;
  assign rd_off   = 12'({p, r, c});
  assign busy       = (state != IDLE);
  assign frame_done = done_q;

  always_comb begin
    state_n      = state;
    mem_read     = 1'b0;
    mem_read_idx = 12'h000;
    out_valid    = 1'b0;
    out_byte     = 8'h00;
    out_first    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = LOAD;
      end
      LOAD: begin
        mem_read = !mem_read_ack;
        if (mem_read) mem_read_idx = FB_BASE + rd_off;
        if (mem_read_ack && (r == 3'd7)) state_n = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        for (int k = 0; k < 8; k++)
          out_byte[k] = rows[k][3'd7 - col];
        out_first = (p == '0) && (c == 3'd0) && (j == '0);
        if (out_ready && j_last)
          state_n = last_blk ? IDLE : LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      p      <= '0;
      c      <= '0;
      r      <= '0;
      j      <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= hs && j_last && last_blk;
      if ((state == IDLE) && start) begin
        p <= '0;
        c <= '0;
        r <= '0;
        j <= '0;
      end
      if ((state == LOAD) && mem_read_ack)
        r <= r + 3'd1;
      if (hs) begin
        j <= j + 1'b1;
        if (j_last && !last_blk) begin
          c <= c + 3'd1;
          if (c == 3'd7) p <= p + 1'b1;
        end
      end
    end
  end

  // row buffer needs no reset: it is always refilled before EMIT
  always_ff @(posedge clk) begin
    if ((state == LOAD) && mem_read_ack)
      rows[r] <= mem_read_byte;
  end

endmodule

// File: doc/screen_scanner.md
# screen_scanner

Reads the 64x32 monochrome frame buffer that the sprite drawing unit maintains at 0x100–0x1FF and streams it out as SSD1306-style page bytes. Each output byte carries 8 vertically stacked pixels. Output order is horizontal addressing mode: page 0 columns 0..63, then page 1, page 2, page 3. It shares the memory read handshake used by the other memory clients and feeds the serial display driver through a valid/ready byte stream.

## Interface
Parameters:
- FB_BASE, 12'h100, frame buffer base address; row r, byte-column c is at FB_BASE + r*8 + c.
- PAGES, 4, number of 8-row pages (32 rows).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- start  in  1  request one frame scan; sampled only in IDLE.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.
- mem_read  out  1  read request.
- mem_read_idx  out  12  read address.
- mem_read_byte  in  8  read data, valid in the cycle mem_read_ack is high.
- mem_read_ack  in  1  read completion.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- out_byte  out  8  page byte; bit k is pixel row 8*page+k.
- out_first  out  1  high with the first byte of a frame.

## Operation
- Frame buffer format: bit 7 of a byte is the leftmost pixel; byte (r, c) covers pixels x = 8c..8c+7.
- The frame is processed as 32 blocks, ordered with p = 0..3 as the outer loop and c = 0..7 as the inner loop. Each block covers 8 rows x 8 columns.
- State IDLE -> LOAD when start is seen. Counters p, c, r and j are cleared, and out_first is armed.
- LOAD, r = 0..7:
  - mem_read = !mem_read_ack, combinational.
  - mem_read_idx = FB_BASE + (8p+r)*8 + c.
  - On ack, mem_read_byte is stored in row buffer[r] and r increments.
  - After the ack for r = 7, go to EMIT.
- EMIT, j = 0..7:
  - out_valid = 1.
  - out_byte[k] = buffer[k][7-j].
  - Each handshake advances j.
  - After the handshake for j = 7: if c = 7 and p = PAGES-1, go to IDLE and pulse frame_done; otherwise advance c (wrapping to 0 and incrementing p) and return to LOAD.
- out_first is high only while (p, c, j) = (0, 0, 0) on the first emission of the frame.
- start while busy is ignored; no queuing.
- mem_read_idx is 0 whenever mem_read is low.

## Timing
- Reset values:
  - State IDLE.
  - busy, frame_done, mem_read, out_valid and out_first are 0.
  - mem_read_idx and out_byte are 0.
  - Row buffer contents are don't-care.
- start sampled at edge N: busy and mem_read are high from cycle N+1.
- Memory latency is arbitrary. mem_read stays high until the ack cycle and drops in the ack cycle. The next read is issued the following cycle, so with 1-cycle ack latency each read takes 2 cycles.
- out_byte and out_first must stay stable while out_valid && !out_ready. out_valid never drops without a handshake.
- First out_valid comes 1 cycle after the 8th ack of block 0.
- The cycle after the last handshake: busy = 0 and frame_done = 1 for exactly that cycle.
- With out_ready held high and 1-cycle memory, a frame takes 32*(16+8) = 768 cycles (cycle counts in this section assume SCANNER_HDOUBLE_EN undefined).
- rst_n low mid-frame: back to IDLE at that edge, with mem_read and out_valid low. No partial frame_done is produced.
- start and rst_n low in the same cycle: reset wins.

## Configuration
- SCANNER_HDOUBLE_EN defined:
  - Each column byte is emitted twice in consecutive handshakes, giving 16 handshakes per block and 512 bytes per frame, for a 128x32 panel.
  - out_first is high on the first copy only.
  - Frame time becomes 32*(16+16) = 1024 cycles.
- SCANNER_HDOUBLE_EN undefined: 256 bytes per frame, as described above.

## Test plan
- All-zero buffer, start, out_ready=1, 1-cycle ack:
  - 256 bytes of 0x00.
  - out_first on byte 0 only.
  - frame_done at cycle 769 after start.
  - Reads visit addresses 0x100, 0x108, ..., 0x138, then 0x101, ... in block order.
- Byte 0x100 = 0x80, rest 0: byte 0 = 0x01, all other bytes 0x00.
- Byte 0x1FF = 0x01, rest 0: byte 255 = 0x80, all others 0x00.
- Byte 0x108 = 0xFF: bytes 0..7 = 0x02.
- Random out_ready backpressure plus random 1–5 cycle ack latency: the captured stream matches the reference transpose. out_byte is stable while stalled. A start pulsed mid-frame has no effect.
- rst_n low at handshake 100 then released, then a new start: busy drops at the reset edge. The new frame is complete and correct, with exactly one frame_done.
- With SCANNER_HDOUBLE_EN and 0x100 = 0x80: bytes 0 and 1 = 0x01, all others 0. Total 512 bytes.
